// File: rtl/qos_io_pkg.sv
// rtl/qos_io_pkg.sv - shared widths, limits and FSM state type for the QoS link output path
package qos_io_pkg;
  localparam int NUM_W       = 4;
  localparam int COUNT_W     = 12;
  localparam int MIN_GAP_LEN = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    START_GAP,
    BIT,
    BIT_GAP
  } send_state_t;
endpackage

// File: rtl/num_fifo.sv
// rtl/num_fifo.sv - small number FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module num_fifo #(
  parameter int DEPTH = 4,
  parameter int NUM_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [NUM_W-1:0] din,
  output logic [NUM_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [NUM_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/send_output.sv
// rtl/send_output.sv - serialises queued numbers onto active-low start/high/low strobes; SEND_DROP_COUNT_EN adds drop_count
module send_output
  import qos_io_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_W-1:0]   in_number,
  input  logic               in_push,
  output logic               full,
  output logic               busy,
  output logic               start_line,
  output logic               high_line,
  output logic               low_line,
  output logic [COUNT_W-1:0] sent_count
`ifdef SEND_DROP_COUNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);
  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(NUM_W);
  localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = 1;
  localparam logic [IDX_W-1:0]   IDX_MSB    = IDX_W'(NUM_W - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = 1;
  localparam logic [COUNT_W-1:0] SENT_ONE   = 1;

  send_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_W-1:0]   sh_q, sh_d;
  logic [COUNT_W-1:0] sent_count_q, sent_count_d;
  logic               start_q, start_d;
  logic               high_q, high_d;
  logic               low_q, low_d;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [NUM_W-1:0]   fifo_dout;

  num_fifo #(
    .DEPTH (DEPTH),
    .NUM_W (NUM_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_push),
    .pop   (fifo_pop),
    .din   (in_number),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    sent_count_d = sent_count_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = START_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      START_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = IDX_MSB;
          state_d = BIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BIT: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = BIT_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BIT_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_ONE;
            state_d = BIT;
          end else begin
            // Frame done: chain straight into the next one so back-to-back frames have no idle cycle.
            sent_count_d = sent_count_q + SENT_ONE;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sh_d     = fifo_dout;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = !(state_d == START);
    high_d  = !((state_d == BIT) && sh_d[idx_d]);
    low_d   = !((state_d == BIT) && !sh_d[idx_d]);
  end

  // Lines are registered from the next state so they change only on clock edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      sent_count_q <= '0;
      start_q      <= 1'b1;
      high_q       <= 1'b1;
      low_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      sent_count_q <= sent_count_d;
      start_q      <= start_d;
      high_q       <= high_d;
      low_q        <= low_d;
    end
  end

  assign full       = fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign start_line = start_q;
  assign high_line  = high_q;
  assign low_line   = low_q;
  assign sent_count = sent_count_q;

`ifdef SEND_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;
  logic       drop;

  assign drop = in_push && fifo_full && !fifo_pop;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    assert ((GAP_LEN >= MIN_GAP_LEN) && (PULSE_LEN >= 1))
      else $error("send_output: GAP_LEN must be >= 3 and PULSE_LEN >= 1");
  end
`endif
endmodule

// File: tb/tb_send_output.sv
// tb/tb_send_output.sv - self-checking bench for send_output with a line-level receiver model
module tb_send_output;
  localparam int P = 2;
  localparam int G = 4;
  localparam int D = 4;
  localparam int FRAME = 5 * (P + G);

  logic        clock;
  logic        reset;
  logic [3:0]  in_number;
  logic        in_push;
  logic        full;
  logic        busy;
  logic        start_line;
  logic        high_line;
  logic        low_line;
  logic [11:0] sent_count;
`ifdef SEND_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_sent = 0;
  int exp_drop = 0;

  send_output #(
    .DEPTH     (D),
    .PULSE_LEN (P),
    .GAP_LEN   (G)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_number  (in_number),
    .in_push    (in_push),
    .full       (full),
    .busy       (busy),
    .start_line (start_line),
    .high_line  (high_line),
    .low_line   (low_line),
    .sent_count (sent_count)
`ifdef SEND_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Ideal line waveform {start,high,low} for offset t within a frame carrying v.
  function automatic logic [2:0] frame_lines(input logic [3:0] v, input int t);
    int slot;
    int pos;
    if (t < 0 || t >= FRAME) return 3'b111;
    slot = t / (P + G);
    pos  = t % (P + G);
    if (pos >= P) return 3'b111;
    if (slot == 0) return 3'b011;
    return v[4 - slot] ? 3'b101 : 3'b110;
  endfunction

  // Far-end receiver: falling start begins a frame, falling high/low shifts a bit in.
  logic [2:0] prev_lines = 3'b111;
  logic [3:0] rx_sh;
  int         rx_n = 0;
  bit         rx_act = 0;
  int         rx_q[$];
  int         start_q[$];
  int         low_cycles = 0;

  always @(negedge clock) begin
    logic [2:0] cur;
    cur = {start_line, high_line, low_line};
    if (reset) begin
      rx_act     = 0;
      prev_lines = 3'b111;
    end else begin
      if (cur != 3'b111) begin
        low_cycles++;
        checks++;
        if ($countones(~cur) > 1) begin
          errors++;
          $display("FAIL exclusivity: lines=%b at cycle %0d, at most one low required", cur, cyc);
        end
      end
      if (prev_lines[2] && !cur[2]) begin
        rx_act = 1;
        rx_n   = 0;
        rx_sh  = '0;
        start_q.push_back(cyc);
      end else if (rx_act && prev_lines[1] && !cur[1]) begin
        rx_sh = {rx_sh[2:0], 1'b1};
        rx_n++;
      end else if (rx_act && prev_lines[0] && !cur[0]) begin
        rx_sh = {rx_sh[2:0], 1'b0};
        rx_n++;
      end
      if (rx_act && rx_n == 4) begin
        rx_q.push_back(int'(rx_sh));
        rx_act = 0;
      end
      prev_lines = cur;
    end
  end

  task automatic wait_rx(input int n, input int budget);
    int w = 0;
    while (rx_q.size() < n && w < budget) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL wait_rx: received %0d frames, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clock);
    while (busy !== 1'b0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic check_sent(input string name);
    checks++;
    if (sent_count !== 12'(exp_sent)) begin
      errors++;
      $display("FAIL %s sent_count: got %0d, required %0d", name, sent_count, exp_sent % 4096);
    end
  endtask

  task automatic check_rx(input string name, input int exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s rx[%0d]: got %0d, required %0d", name, i,
                 (i < rx_q.size()) ? rx_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({start_line, high_line, low_line, full, busy} !== 5'b11100 || sent_count !== 12'd0) begin
      errors++;
      $display("FAIL reset: lines/full/busy=%b sent=%0d, required 11100 and 0",
               {start_line, high_line, low_line, full, busy}, sent_count);
    end
`ifdef SEND_DROP_COUNT_EN
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset drop_count: got %0d, required 0", drop_count);
    end
`endif
    reset = 1'b0;
    exp_sent = 0;
    exp_drop = 0;
  endtask

  task automatic test_single();
    logic [3:0] v;
    logic [2:0] got;
    logic [2:0] exp;
    int k;
    v = 4'b1011;
    wait_idle();
    rx_q.delete();
    @(negedge clock);
    in_number = v;
    in_push   = 1'b1;
    k         = cyc;
    @(negedge clock);
    in_push = 1'b0;
    for (int t = 0; t < FRAME + 2; t++) begin
      @(negedge clock);
      got = {start_line, high_line, low_line};
      exp = frame_lines(v, cyc - k - 2);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single waveform at offset %0d: got %b, required %b", cyc - k, got, exp);
      end
    end
    exp_sent++;
    check_sent("single");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single busy: got %b, required 0", busy);
    end
    check_rx("single", '{11});
  endtask

  task automatic test_back_to_back();
    wait_idle();
    rx_q.delete();
    start_q.delete();
    @(negedge clock);
    in_number = 4'd0;
    in_push   = 1'b1;
    @(negedge clock);
    in_number = 4'd15;
    @(negedge clock);
    in_push = 1'b0;
    wait_rx(2, 2 * FRAME + 20);
    checks++;
    if (start_q.size() < 2 || start_q[1] - start_q[0] != FRAME) begin
      errors++;
      $display("FAIL back_to_back spacing: got %0d, required %0d",
               (start_q.size() < 2) ? -1 : start_q[1] - start_q[0], FRAME);
    end
    check_rx("back_to_back", '{0, 15});
    wait_idle();
    exp_sent += 2;
    check_sent("back_to_back");
  endtask

  task automatic test_random();
    int exp_q[$];
    logic [3:0] v;
    wait_idle();
    rx_q.delete();
    for (int n = 0; n < 6; n++) begin
      v = 4'($urandom);
      exp_q.push_back(int'(v));
      @(negedge clock);
      in_number = v;
      in_push   = 1'b1;
      @(negedge clock);
      in_push = 1'b0;
      repeat ($urandom_range(20, 40)) @(negedge clock);
    end
    wait_rx(6, 6 * FRAME + 60);
    check_rx("random", exp_q);
    wait_idle();
    exp_sent += 6;
    check_sent("random");
  endtask

  task automatic test_overflow();
    int exp_q[$];
    int occ;
    int drops;
    logic [3:0] v;
    wait_idle();
    rx_q.delete();
    v = 4'($urandom);
    exp_q.push_back(int'(v));
    @(negedge clock);
    in_number = v;
    in_push   = 1'b1;
    @(negedge clock);
    in_push = 1'b0;
    repeat (2) @(negedge clock);
    occ   = 0;
    drops = 0;
    for (int n = 0; n < 6; n++) begin
      v = 4'($urandom);
      @(negedge clock);
      in_number = v;
      in_push   = 1'b1;
      if (occ < D) begin
        occ++;
        exp_q.push_back(int'(v));
      end else begin
        drops++;
      end
    end
    @(negedge clock);
    in_push = 1'b0;
    checks++;
    if (full !== (occ == D)) begin
      errors++;
      $display("FAIL overflow full: got %b, required %b", full, occ == D);
    end
    exp_drop += drops;
`ifdef SEND_DROP_COUNT_EN
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL overflow drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
`endif
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 60);
    check_rx("overflow", exp_q);
    wait_idle();
    exp_sent += exp_q.size();
    check_sent("overflow");
  endtask

  task automatic test_push_pop_full();
    int exp_q[$];
    int k;
    int w;
    logic [3:0] v;
    wait_idle();
    rx_q.delete();
    for (int n = 0; n < 5; n++) begin
      v = 4'($urandom);
      exp_q.push_back(int'(v));
      @(negedge clock);
      in_number = v;
      in_push   = 1'b1;
      if (n == 0) k = cyc;
    end
    @(negedge clock);
    in_push = 1'b0;
    // The first frame's last gap cycle is k+2+FRAME-1; that is when the next entry is popped.
    w = 0;
    while (cyc < k + 1 + FRAME && w < 100) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_full full before pop: got %b, required 1", full);
    end
    v = 4'($urandom);
    exp_q.push_back(int'(v));
    in_number = v;
    in_push   = 1'b1;
    @(negedge clock);
    in_push = 1'b0;
`ifdef SEND_DROP_COUNT_EN
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL push_pop_full drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
`endif
    wait_rx(6, 6 * FRAME + 60);
    check_rx("push_pop_full", exp_q);
    wait_idle();
    exp_sent += 6;
    check_sent("push_pop_full");
  endtask

  task automatic test_reset_mid();
    int k;
    int w;
    int lows_before;
    logic [3:0] v;
    wait_idle();
    v = 4'($urandom);
    @(negedge clock);
    in_number = v;
    in_push   = 1'b1;
    k         = cyc;
    @(negedge clock);
    in_number = 4'($urandom);
    @(negedge clock);
    in_number = 4'($urandom);
    @(negedge clock);
    in_push = 1'b0;
    w = 0;
    while (cyc < k + 2 + 3 * (P + G) && w < 100) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if ({start_line, high_line, low_line} !== frame_lines(v, 3 * (P + G))) begin
      errors++;
      $display("FAIL reset_mid third strobe: got %b, required %b",
               {start_line, high_line, low_line}, frame_lines(v, 3 * (P + G)));
    end
    reset = 1'b1;
    @(negedge clock);
    exp_sent = 0;
    exp_drop = 0;
    checks++;
    if ({start_line, high_line, low_line, busy, full} !== 5'b11100 || sent_count !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid state: lines/busy/full=%b sent=%0d, required 11100 and 0",
               {start_line, high_line, low_line, busy, full}, sent_count);
    end
    reset = 1'b0;
    lows_before = low_cycles;
    repeat (2 * FRAME) @(negedge clock);
    checks++;
    if (low_cycles != lows_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid quiet: %0d strobe cycles busy=%b, required 0 and 0",
               low_cycles - lows_before, busy);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    wait_idle();
    rx_q.delete();
    @(negedge clock);
    force dut.sent_count_q = 12'hFFF;
    @(negedge clock);
    release dut.sent_count_q;
    exp_sent = 4095;
    @(negedge clock);
    check_sent("wrap preset");
    v = 4'($urandom);
    @(negedge clock);
    in_number = v;
    in_push   = 1'b1;
    @(negedge clock);
    in_push = 1'b0;
    wait_rx(1, FRAME + 20);
    check_rx("wrap", '{int'(v)});
    wait_idle();
    exp_sent = (exp_sent + 1) % 4096;
    check_sent("wrap");
  endtask

  initial begin
    reset     = 1'b1;
    in_push   = 1'b0;
    in_number = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
